// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and instruction constants for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - instruction memory bus between the fetch stage and imem
interface pc_fetch_stage_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load enable and flush-to-NOP
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [DATA_W-1:0] i_pc_plus4,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic              o_valid
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;

  // Flush wins over load; a flush keeps pc_plus4 so ID still sees the last link value.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (i_flush) begin
      instr_d = DATA_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (i_enable) begin
      instr_d    = i_instr;
      pc_plus4_d = i_pc_plus4;
      valid_d    = 1'b1;
    end
  end

  // IF/ID storage, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instr_q    <= DATA_W'(NOP_INSTR);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC/fetch stage with IDLE/RUN/HALTED control; FETCH_STEP_EN adds single-step inputs
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEFAULT)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stall,
`ifdef FETCH_STEP_EN
  input  logic                     i_step_mode,
  input  logic                     i_step,
`endif
  input  logic                     i_pc_mux_ctrl,
  input  logic [DATA_W-1:0]        i_target,
  pc_fetch_stage_if.master         imem,
  output logic [DATA_W-1:0]        o_instr,
  output logic [DATA_W-1:0]        o_pc_plus4,
  output logic                     o_valid,
  output logic                     o_halted
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;

  logic              stall_eff;
  logic              active;
  logic              redirect;
  logic              advance;
  logic              is_halt;
  logic [DATA_W-1:0] pc_plus4;

  // In step mode every cycle without a step pulse is treated exactly like a hazard stall.
`ifdef FETCH_STEP_EN
  assign stall_eff = i_stall | (i_step_mode & ~i_step);
`else
  assign stall_eff = i_stall;
`endif

  // Priority: stall, then redirect, then sequential advance; only RUN moves anything.
  always_comb begin
    active   = (state_q == ST_RUN) && !stall_eff;
    redirect = active && i_pc_mux_ctrl;
    advance  = active && !i_pc_mux_ctrl;
    is_halt  = (imem.imem_data == HALT_INSTR);
    pc_plus4 = pc_q + DATA_W'(4);
  end

  // Next PC, state and halt flag; a halt fetched on a redirect cycle is simply dropped.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d = i_target;
        end else if (advance) begin
          if (is_halt) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        halted_d = 1'b0;
      end
    endcase
  end

  // Control state and PC register, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (advance),
    .i_flush    (redirect),
    .i_instr    (imem.imem_data),
    .i_pc_plus4 (pc_plus4),
    .o_instr    (o_instr),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_valid)
  );

  assign imem.imem_addr = pc_q;
  assign o_halted       = halted_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

  localparam logic [31:0] INSTR_A = 32'hA000_0001;
  localparam logic [31:0] INSTR_B = 32'hB000_0002;
  localparam logic [31:0] INSTR_C = 32'hC000_0003;
  localparam logic [31:0] INSTR_E = 32'hE000_0005;
  localparam logic [31:0] INSTR_F = 32'hF000_0006;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        step_mode;
  logic        step;
  logic        pc_mux_ctrl;
  logic [31:0] target;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_stage_if #(.DATA_W(32)) imem_bus ();

  assign imem_bus.imem_data = mem[imem_bus.imem_addr[9:2]];

  pc_fetch_stage #(
    .DATA_W     (32),
    .RESET_PC   (32'h0),
    .HALT_INSTR (HALT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stall       (stall),
`ifdef FETCH_STEP_EN
    .i_step_mode   (step_mode),
    .i_step        (step),
`endif
    .i_pc_mux_ctrl (pc_mux_ctrl),
    .i_target      (target),
    .imem          (imem_bus.master),
    .o_instr       (instr),
    .o_pc_plus4    (pc_plus4),
    .o_valid       (valid),
    .o_halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
    check({tag, ".addr"},  imem_bus.imem_addr, addr);
    check({tag, ".instr"}, instr, ins);
    check({tag, ".pc4"},   pc_plus4, p4);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_ifid(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    check({tag, ".halted"}, {31'b0, halted}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 + i;
    mem[0]    = INSTR_A;
    mem[1]    = INSTR_B;
    mem[2]    = INSTR_C;
    mem[3]    = HALT;
    mem[8'h10] = INSTR_E;
    mem[8'hFF] = INSTR_F;

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
    pc_mux_ctrl = 1'b0; target = 32'h0;

    // reset and idle hold
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_ifid("idle", 32'h0, 32'h0, 32'h0, 1'b0);

    // start and three sequential fetches
    start = 1'b1;
    tick();
    start = 1'b0;
    check_ifid("run_entry", 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("fetch_a", 32'h4, INSTR_A, 32'h4, 1'b1);
    tick();
    check_ifid("fetch_b", 32'h8, INSTR_B, 32'h8, 1'b1);

    // stall three cycles at PC=8 with a redirect that must be ignored
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc_mux_ctrl = (k == 1);
      target      = 32'h40;
      tick();
      check_ifid("stall", 32'h8, INSTR_B, 32'h8, 1'b1);
    end
    stall = 1'b0;
    pc_mux_ctrl = 1'b0;
    tick();
    check_ifid("fetch_c", 32'hC, INSTR_C, 32'hC, 1'b1);

    // redirect to 0x40 flushes IF/ID, then fetches imem[0x40]
    pc_mux_ctrl = 1'b1;
    target = 32'h40;
    tick();
    pc_mux_ctrl = 1'b0;
    check_ifid("redirect", 32'h40, 32'h0, 32'hC, 1'b0);
    tick();
    check_ifid("fetch_e", 32'h44, INSTR_E, 32'h44, 1'b1);

    // redirect to 12 then fetch HALT
    pc_mux_ctrl = 1'b1;
    target = 32'hC;
    tick();
    pc_mux_ctrl = 1'b0;
    check_ifid("to_halt", 32'hC, 32'h0, 32'h44, 1'b0);
    tick();
    check_ifid("halt", 32'hC, HALT, 32'h10, 1'b1);
    check("halt.halted", {31'b0, halted}, 32'h1);

    // HALTED ignores start and redirect
    start = 1'b1;
    pc_mux_ctrl = 1'b1;
    target = 32'h40;
    tick();
    tick();
    start = 1'b0;
    pc_mux_ctrl = 1'b0;
    check_ifid("halted_hold", 32'hC, HALT, 32'h10, 1'b1);
    check("halted_hold.halted", {31'b0, halted}, 32'h1);

    // asynchronous reset out of HALTED
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_halted");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_rst_idle");

    // HALT at the PC on a redirect cycle is discarded
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_mux_ctrl = 1'b1;
    target = 32'hC;
    tick();
    target = 32'h40;
    tick();
    pc_mux_ctrl = 1'b0;
    check_ifid("halt_redirect", 32'h40, 32'h0, 32'h0, 1'b0);
    check("halt_redirect.halted", {31'b0, halted}, 32'h0);
    tick();
    check_ifid("after_redirect", 32'h44, INSTR_E, 32'h44, 1'b1);

    // PC+4 wraps modulo 2^32
    pc_mux_ctrl = 1'b1;
    target = 32'hFFFF_FFFC;
    tick();
    pc_mux_ctrl = 1'b0;
    check("wrap_pre.addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_ifid("wrap", 32'h0, INSTR_F, 32'h0, 1'b1);

    // reset mid-run, between clock edges
    tick();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_midrun");
    rst_n = 1'b1;
    tick();

`ifdef FETCH_STEP_EN
    // step mode: no movement without a pulse, exactly 4 bytes per pulse
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("step_idle.addr", imem_bus.imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
    end
    check_ifid("step", 32'hC, INSTR_C, 32'hC, 1'b1);
    check("step.halted", {31'b0, halted}, 32'h0);
    step_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
